// File: rtl/mem_access_stage.sv
// MEM stage: data RAM access, result in 1 cycle (WAIT_CYCLES+1 on loads/stores). Stall holds upstream for WAIT_CYCLES.
// Optional MEM_BOUNDS_CHECK_EN flags and suppresses accesses with nonzero address bits above the RAM index.
module mem_access_stage #(
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dataIn_wE_BR,
   input  logic        dataIn_W_ram,
   input  logic        dataIn_R_ram,
   input  logic [0:31] dataIn_DW_alu,
   input  logic [0:31] dataIn_DR2,
   output logic        dataOut_wE_BR,
   output logic [0:31] dataOut_DW,
   output logic        stall
`ifdef MEM_BOUNDS_CHECK_EN
   ,
   output logic        mem_err
`endif
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          we_br_q, we_br_d;
   logic [0:31]   dw_q, dw_d;
`ifdef MEM_BOUNDS_CHECK_EN
   logic          err_q, err_d;
`endif

   logic [0:31]   ram [0:DEPTH-1];
   logic [AW-1:0] idx;
   logic          req;
   logic          done;
   logic          oob;
   logic          ram_we;

   assign idx = dataIn_DW_alu[32-AW:31];
   assign req = dataIn_W_ram | dataIn_R_ram;

`ifdef MEM_BOUNDS_CHECK_EN
   assign oob = req && (dataIn_DW_alu[0:31-AW] != '0);
`else
   assign oob = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_br_d = we_br_q;
      dw_d    = dw_q;
`ifdef MEM_BOUNDS_CHECK_EN
      err_d   = 1'b0;
`endif
      stall   = 1'b0;
      done    = 1'b0;

      case (state_q)
         IDLE: begin
            if (!req || WAIT_CYCLES == 0) begin
               done = 1'b1;
            end else begin
               stall   = 1'b1;
               cnt_d   = 3'(WAIT_CYCLES - 1);
               state_d = BUSY;
               we_br_d = 1'b0;
            end
         end
         BUSY: begin
            if (cnt_q != 3'd0) begin
               stall   = 1'b1;
               cnt_d   = cnt_q - 3'd1;
               we_br_d = 1'b0;
            end else begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Inputs are only consumed on the completing edge; upstream holds them until then.
      if (done) begin
         we_br_d = dataIn_wE_BR;
`ifdef MEM_BOUNDS_CHECK_EN
         err_d   = oob;
`endif
         if (dataIn_R_ram) begin
            dw_d = oob ? '0 : ram[idx];
         end else begin
            dw_d = dataIn_DW_alu;
         end
      end

      // Reset aborts an access in flight, so upstream must be released at once.
      if (!rst_n) begin
         stall = 1'b0;
      end
   end

   assign ram_we = done && dataIn_W_ram && !oob && rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         we_br_q <= 1'b0;
         dw_q    <= '0;
`ifdef MEM_BOUNDS_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_br_q <= we_br_d;
         dw_q    <= dw_d;
`ifdef MEM_BOUNDS_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

   // Read data is taken combinationally above, so a same-edge write returns the old word.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[idx] <= dataIn_DR2;
      end
   end

   assign dataOut_wE_BR = we_br_q;
   assign dataOut_DW    = dw_q;
`ifdef MEM_BOUNDS_CHECK_EN
   assign mem_err       = err_q;
`endif

endmodule
